// File: rtl/seg7_scan_driver.sv
// Multi-digit 7-segment driver. Digit codes are shadowed and committed at the frame boundary.
// Outputs are a parallel per-digit segment bus and a scanned segment/anode pair.
module seg7_scan_driver #(
   parameter int NDIG      = 8,
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5*NDIG-1:0]   value_in,
   input  logic [NDIG-1:0]     dp_in,
   input  logic                load,
   input  logic [NDIG-1:0]     blank_mask,
   input  logic [NDIG-1:0]     blink_mask,
   input  logic                lz_en,
   output logic                upd_pend,
   output logic [8*NDIG-1:0]   seg_par,
   output logic [7:0]          seg_scan,
   output logic [NDIG-1:0]     an
);
   localparam int IW = $clog2(NDIG);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [NDIG-1:0] AN_ONE = {{(NDIG-1){1'b0}}, 1'b1};

   logic [5*NDIG-1:0] shadow_code_r;
   logic [5*NDIG-1:0] active_code_r;
   logic [NDIG-1:0]   shadow_dp_r;
   logic [NDIG-1:0]   active_dp_r;
   logic [DW-1:0]     div_cnt_r;
   logic [IW-1:0]     idx_r;
   logic [BW-1:0]     blink_cnt_r;
   logic              blink_ph_r;
   logic              upd_pend_r;
   logic [8*NDIG-1:0] seg_par_r;
   logic [7:0]        seg_scan_r;
   logic [NDIG-1:0]   an_r;

   logic [8*NDIG-1:0] seg_s;
   logic [NDIG-1:0]   lz_s;
   logic              zero_run_s;
   logic              div_wrap_s;
   logic              frame_wrap_s;
   logic              blink_wrap_s;

   // Active-high glyph for a 5-bit code: 0-F hex, 16 = minus, everything else blank.
   function automatic logic [7:0] glyph(input logic [4:0] code);
      logic [7:0] g;
      case (code)
         5'd0:    g = 8'hFC;
         5'd1:    g = 8'h60;
         5'd2:    g = 8'hDA;
         5'd3:    g = 8'hF2;
         5'd4:    g = 8'h66;
         5'd5:    g = 8'hB6;
         5'd6:    g = 8'hBE;
         5'd7:    g = 8'hE0;
         5'd8:    g = 8'hFE;
         5'd9:    g = 8'hF6;
         5'd10:   g = 8'hEE;
         5'd11:   g = 8'h3E;
         5'd12:   g = 8'h9C;
         5'd13:   g = 8'h7A;
         5'd14:   g = 8'h9E;
         5'd15:   g = 8'h8E;
         5'd16:   g = 8'h02;
         default: g = 8'h00;
      endcase
      return g;
   endfunction

   assign div_wrap_s   = (div_cnt_r == DW'(SCAN_DIV - 1));
   assign frame_wrap_s = div_wrap_s && (idx_r == IW'(NDIG - 1));
   assign blink_wrap_s = (blink_cnt_r == BW'(BLINK_DIV - 1));

   // Leading-zero run from the top digit down, then per-digit byte with darkening.
   always_comb begin
      zero_run_s = 1'b1;
      lz_s       = '0;
      seg_s      = '1;
      for (int i = NDIG - 1; i >= 0; i--) begin
         zero_run_s = zero_run_s & (active_code_r[5*i +: 5] == 5'd0);
         lz_s[i]    = lz_en & zero_run_s & (i != 0);
      end
      for (int i = 0; i < NDIG; i++) begin
         if (blank_mask[i] | (blink_mask[i] & blink_ph_r) | lz_s[i]) begin
            seg_s[8*i +: 8] = 8'hFF;
         end else begin
            seg_s[8*i +: 8] = ~(glyph(active_code_r[5*i +: 5]) | {7'd0, active_dp_r[i]});
         end
      end
   end

   // Scan and blink timebases.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_r   <= '0;
         idx_r       <= '0;
         blink_cnt_r <= '0;
         blink_ph_r  <= 1'b0;
      end else begin
         div_cnt_r <= div_wrap_s ? '0 : div_cnt_r + DW'(1);
         if (div_wrap_s) begin
            idx_r <= (idx_r == IW'(NDIG - 1)) ? '0 : idx_r + IW'(1);
         end
         blink_cnt_r <= blink_wrap_s ? '0 : blink_cnt_r + BW'(1);
         if (blink_wrap_s) begin
            blink_ph_r <= ~blink_ph_r;
         end
      end
   end

   // Shadow/active pair: a load on the wrap cycle lands in shadow and waits one more frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_code_r <= '0;
         shadow_dp_r   <= '0;
         active_code_r <= '0;
         active_dp_r   <= '0;
         upd_pend_r    <= 1'b0;
      end else begin
         if (frame_wrap_s) begin
            active_code_r <= shadow_code_r;
            active_dp_r   <= shadow_dp_r;
         end
         if (load) begin
            shadow_code_r <= value_in;
            shadow_dp_r   <= dp_in;
            upd_pend_r    <= 1'b1;
         end else if (frame_wrap_s) begin
            upd_pend_r    <= 1'b0;
         end
      end
   end

   // Output registers; seg_scan and an are sampled from the same idx so they stay paired.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_par_r  <= '1;
         seg_scan_r <= 8'hFF;
         an_r       <= '1;
      end else begin
         seg_par_r  <= seg_s;
         seg_scan_r <= seg_s[{idx_r, 3'b000} +: 8];
         an_r       <= ~(AN_ONE << idx_r);
      end
   end

   assign upd_pend = upd_pend_r;
   assign seg_par  = seg_par_r;
   assign seg_scan = seg_scan_r;
   assign an       = an_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NDIG=4, SCAN_DIV=4, BLINK_DIV=8.
module tb_seg7_scan_driver;
   localparam int NDIG = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [5*NDIG-1:0]  value_in;
   logic [NDIG-1:0]    dp_in;
   logic               load;
   logic [NDIG-1:0]    blank_mask;
   logic [NDIG-1:0]    blink_mask;
   logic               lz_en;
   logic               upd_pend;
   logic [8*NDIG-1:0]  seg_par;
   logic [7:0]         seg_scan;
   logic [NDIG-1:0]    an;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.NDIG(4), .SCAN_DIV(4), .BLINK_DIV(8)) dut (
      .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .load(load),
      .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
      .upd_pend(upd_pend), .seg_par(seg_par), .seg_scan(seg_scan), .an(an)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h, want %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick(1);
   endtask

   // Anode held 4 clocks per digit; first digit appears one cycle after reset release.
   task automatic scan_check(input logic [31:0] exp_par);
      int idx;
      logic [3:0] exp_an;
      idx    = ((cyc - 1) / 4) % 4;
      exp_an = 4'hF ^ (4'h1 << idx);
      check_val("an", {28'd0, an}, {28'd0, exp_an});
      check_val("seg_scan", {24'd0, seg_scan}, {24'd0, exp_par[idx*8 +: 8]});
   endtask

   task automatic load_val(input logic [19:0] v, input logic [3:0] dp);
      value_in = v;
      dp_in    = dp;
      load     = 1'b1;
      tick(1);
      load     = 1'b0;
   endtask

   function automatic logic [19:0] codes(input logic [4:0] d3, input logic [4:0] d2,
                                         input logic [4:0] d1, input logic [4:0] d0);
      return {d3, d2, d1, d0};
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_par;
      rst = 1'b1; value_in = '0; dp_in = '0; load = 1'b0;
      blank_mask = '0; blink_mask = '0; lz_en = 1'b0;
      tick(3);
      check_val("rst_seg_par", seg_par, 32'hFFFFFFFF);
      check_val("rst_seg_scan", {24'd0, seg_scan}, 32'h000000FF);
      check_val("rst_an", {28'd0, an}, 32'h0000000F);
      check_val("rst_upd_pend", {31'd0, upd_pend}, 32'd0);
      rst = 1'b0;
      cyc = 0;

      // Zero display with full scan sequence
      for (int k = 1; k <= 16; k++) begin
         tick(1);
         if (k == 1) check_val("init_seg_par", seg_par, 32'h03030303);
         scan_check(32'h03030303);
      end

      // Mid-frame load is held until the frame wrap
      run_to(20);
      load_val(codes(5'hF, 5'hA, 5'h1, 5'h0), 4'b0010);
      check_val("pend_set", {31'd0, upd_pend}, 32'd1);
      check_val("hold_par", seg_par, 32'h03030303);
      run_to(31);
      check_val("pend_hold", {31'd0, upd_pend}, 32'd1);
      check_val("hold_par2", seg_par, 32'h03030303);
      run_to(32);
      check_val("pend_clr", {31'd0, upd_pend}, 32'd0);
      tick(1);
      check_val("commit_par", seg_par, 32'h71119E03);
      scan_check(32'h71119E03);

      // Leading-zero suppression, including dp dropped on suppressed digits
      lz_en = 1'b1;
      load_val(codes(5'h0, 5'h0, 5'h0, 5'h0), 4'b1110);
      run_to(48);
      check_val("lz_old_par", seg_par, 32'h71119E03);
      tick(1);
      check_val("lz_all0", seg_par, 32'hFFFFFF03);
      load_val(codes(5'h0, 5'h0, 5'h7, 5'h0), 4'b0000);
      run_to(65);
      check_val("lz_0070", seg_par, 32'hFFFF1F03);

      // Blink on digit 0, 8-clock half period
      lz_en = 1'b0;
      blink_mask = 4'b0001;
      load_val(codes(5'h0, 5'h0, 5'h0, 5'h8), 4'b0000);
      run_to(80);
      for (int k = 0; k < 16; k++) begin
         tick(1);
         exp_par = ((((cyc - 1) / 8) % 2) != 0) ? 32'h030303FF : 32'h03030301;
         check_val("blink_par", seg_par, exp_par);
         scan_check(exp_par);
      end

      // Load on the exact wrap cycle: old shadow commits now, new one next frame
      blink_mask = 4'b0000;
      load_val(codes(5'h1, 5'h2, 5'h3, 5'h4), 4'b0000);
      run_to(111);
      load_val(codes(5'h5, 5'h6, 5'h7, 5'h8), 4'b0000);
      check_val("wrap_pend", {31'd0, upd_pend}, 32'd1);
      tick(1);
      check_val("wrap_old", seg_par, 32'h9F250D99);
      check_val("wrap_pend2", {31'd0, upd_pend}, 32'd1);
      run_to(128);
      check_val("wrap_pend_clr", {31'd0, upd_pend}, 32'd0);
      tick(1);
      check_val("wrap_new", seg_par, 32'h49411F01);

      // Minus, blank code with dp, plain blank code
      load_val(codes(5'd16, 5'd20, 5'd17, 5'd0), 4'b0100);
      run_to(145);
      check_val("special", seg_par, 32'hFDFEFF03);
      scan_check(32'hFDFEFF03);
      blank_mask = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         check_val("blank_par", seg_par, 32'hFFFFFFFF);
         scan_check(32'hFFFFFFFF);
      end

      // Reset with data pending abandons it
      blank_mask = 4'b0000;
      load_val(codes(5'h9, 5'h9, 5'h9, 5'h9), 4'b1111);
      check_val("pre_rst_pend", {31'd0, upd_pend}, 32'd1);
      rst = 1'b1;
      tick(2);
      check_val("mid_rst_pend", {31'd0, upd_pend}, 32'd0);
      check_val("mid_rst_an", {28'd0, an}, 32'h0000000F);
      check_val("mid_rst_par", seg_par, 32'hFFFFFFFF);
      rst = 1'b0;
      cyc = 0;
      tick(1);
      check_val("post_rst_par", seg_par, 32'h03030303);
      scan_check(32'h03030303);
      run_to(17);
      check_val("abandoned", seg_par, 32'h03030303);
      check_val("abandoned_pend", {31'd0, upd_pend}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
